// File: rtl/avalon_mm_loopback_slave.sv
// Avalon-MM loopback slave: DATA push/pop FIFO, STATUS with sticky flags, SCRATCH and ID registers.
// Latency: reads return READ_LATENCY cycles after accept, fully pipelined.
// Backpressure: none; every access is accepted the cycle it is presented.

// Show-ahead FIFO: head_dat is the current head, so a pop can return it in the accept cycle.
// The caller guards push-when-full and pop-when-empty.
module avalon_mm_loopback_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module avalon_mm_loopback_slave #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] ID_VALUE     = 32'hC0DE_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  not_empty
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            a;
  logic                  rd_acc, rd_data, wr_data, wr_status;
  logic                  full, empty, push, pop;
  logic [CW-1:0]         count, cnt_nxt;
  logic [8:0]            cnt9;
  logic [DATA_WIDTH-1:0] head_dat, scratch, status, rsel;
  logic                  ovf, udf, col;
  logic                  pipe_vld [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_dat [READ_LATENCY];

  assign a         = address[1:0];
  // A read colliding with a write is dropped outright; the write still lands.
  assign rd_acc    = read & ~write;
  assign rd_data   = rd_acc && (a == 2'd0);
  assign wr_data   = write && (a == 2'd0);
  assign wr_status = write && (a == 2'd1);
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = wr_data & ~full;
  assign pop       = rd_data & ~empty;
  assign cnt_nxt   = count + CW'(push) - CW'(pop);
  assign cnt9      = 9'(count);

  avalon_mm_loopback_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (writedata),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  always_comb begin
    status     = '0;
    status[7:0] = cnt9[7:0];
    status[16] = empty;
    status[17] = full;
    status[24] = ovf;
    status[25] = udf;
    status[26] = col;
  end

  always_comb begin
    rsel = '0;
    case (a)
      2'd0:    rsel = empty ? '0 : head_dat;
      2'd1:    rsel = status;
      2'd2:    rsel = scratch;
      default: rsel = DATA_WIDTH'(ID_VALUE);
    endcase
  end

  // Sticky flags: a new event in the same cycle as its W1C keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf       <= 1'b0;
      udf       <= 1'b0;
      col       <= 1'b0;
      scratch   <= '0;
      not_empty <= 1'b0;
    end else begin
      ovf       <= (wr_data & full)   | (ovf & ~(wr_status & writedata[24]));
      udf       <= (rd_data & empty)  | (udf & ~(wr_status & writedata[25]));
      col       <= (read & write)     | (col & ~(wr_status & writedata[26]));
      if (write && (a == 2'd2)) scratch <= writedata;
      not_empty <= (cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_dat[0] <= rd_acc ? rsel : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign readdata      = pipe_dat[READ_LATENCY-1];
  assign readdatavalid = pipe_vld[READ_LATENCY-1];

  logic unused_ok;
  assign unused_ok = ^{1'b0, address[ADDR_WIDTH-1:2], cnt9[8]};
endmodule

// File: tb/tb_avalon_mm_loopback_slave.sv
// Scoreboard bench for avalon_mm_loopback_slave: three instances at read latencies 2, 1 and 4.
module tb_avalon_mm_loopback_slave;
  localparam int LAT [3] = '{2, 1, 4};
  localparam logic [31:0] ID = 32'hC0DE_0001;

  logic        clk = 1'b0;
  int          cyc = 0;
  logic        rst_a  [3];
  logic        read_a [3];
  logic        write_a[3];
  logic [31:0] addr_a [3];
  logic [31:0] wd_a   [3];
  logic [31:0] rd_a   [3];
  logic        rdv_a  [3];
  logic        ne_a   [3];

  typedef struct { int d; logic [31:0] dat; int due; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int n_exp[3] = '{0, 0, 0};
  int n_rdv[3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_mm_loopback_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(16), .READ_LATENCY(2), .ID_VALUE(ID)) u0 (
    .clk(clk), .rst(rst_a[0]), .address(addr_a[0]), .read(read_a[0]), .write(write_a[0]),
    .writedata(wd_a[0]), .readdata(rd_a[0]), .readdatavalid(rdv_a[0]), .not_empty(ne_a[0]));
  avalon_mm_loopback_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(16), .READ_LATENCY(1), .ID_VALUE(ID)) u1 (
    .clk(clk), .rst(rst_a[1]), .address(addr_a[1]), .read(read_a[1]), .write(write_a[1]),
    .writedata(wd_a[1]), .readdata(rd_a[1]), .readdatavalid(rdv_a[1]), .not_empty(ne_a[1]));
  avalon_mm_loopback_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(16), .READ_LATENCY(4), .ID_VALUE(ID)) u2 (
    .clk(clk), .rst(rst_a[2]), .address(addr_a[2]), .read(read_a[2]), .write(write_a[2]),
    .writedata(wd_a[2]), .readdata(rd_a[2]), .readdatavalid(rdv_a[2]), .not_empty(ne_a[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Pops one expectation per readdatavalid pulse; flags pulses nobody asked for and late ones.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rdv_a[d] === 1'b1) begin
          n_rdv[d]++;
          if (q.size() == 0 || q[0].d != d) chk("rdv_unexpected", {31'b0, rdv_a[d]}, 32'd0);
          else begin
            e = q.pop_front();
            chk("rdv_data", rd_a[d], e.dat);
            chk("rdv_cycle", cyc, e.due);
          end
        end
      end
      if (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("rdv_missing_cycle", cyc, e.due);
      end
    end
  endtask

  task automatic xact(input int d, input bit rd, input bit wr, input logic [1:0] a,
                      input logic [31:0] wd, input logic [31:0] ex, input bit want);
    exp_t e;
    @(posedge clk); #1;
    read_a[d]  = rd;
    write_a[d] = wr;
    addr_a[d]  = {30'($urandom()), a};
    wd_a[d]    = wd;
    if (rd && want) begin
      e.d = d; e.dat = ex; e.due = cyc + LAT[d];
      q.push_back(e);
      n_exp[d]++;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      read_a[d] = 1'b0; write_a[d] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wrap(input int d);
    for (int i = 0; i < 10; i++) xact(d, 0, 1, 2'd0, 32'h100 + i, 0, 0);
    for (int i = 10; i < 40; i++) begin
      xact(d, 0, 1, 2'd0, 32'h100 + i, 0, 0);
      xact(d, 1, 0, 2'd0, 0, 32'h100 + i - 10, 1);
    end
    for (int i = 30; i < 40; i++) xact(d, 1, 0, 2'd0, 0, 32'h100 + i, 1);
    idle();
    drain();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b1; read_a[d] = 1'b0; write_a[d] = 1'b0; addr_a[d] = '0; wd_a[d] = '0;
    end
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", rd_a[0], 32'd0);
    chk("reset_rdv", {31'b0, rdv_a[0]}, 32'd0);
    chk("reset_not_empty", {31'b0, ne_a[0]}, 32'd0);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_a[d] = 1'b0;

    // T1: ID and empty STATUS after reset
    xact(0, 1, 0, 2'd3, 0, ID, 1);
    xact(0, 1, 0, 2'd1, 0, 32'h0001_0000, 1);
    idle(); drain();

    // T2: fill to full, then back-to-back drain
    for (int i = 1; i <= 16; i++) xact(0, 0, 1, 2'd0, i, 0, 0);
    idle();
    chk("t2_not_empty_hi", {31'b0, ne_a[0]}, 32'd1);
    xact(0, 1, 0, 2'd1, 0, 32'h0002_0010, 1);
    for (int i = 1; i <= 16; i++) xact(0, 1, 0, 2'd0, 0, i, 1);
    idle(); drain();
    chk("t2_not_empty_lo", {31'b0, ne_a[0]}, 32'd0);

    // T3: overflow, underflow, W1C
    for (int i = 1; i <= 16; i++) xact(0, 0, 1, 2'd0, 32'h1000 + i, 0, 0);
    xact(0, 0, 1, 2'd0, 32'hDEAD_BEEF, 0, 0);
    xact(0, 1, 0, 2'd1, 0, 32'h0102_0010, 1);
    for (int i = 1; i <= 16; i++) xact(0, 1, 0, 2'd0, 0, 32'h1000 + i, 1);
    xact(0, 1, 0, 2'd0, 0, 32'd0, 1);
    xact(0, 1, 0, 2'd1, 0, 32'h0301_0000, 1);
    xact(0, 0, 1, 2'd1, 32'h0300_0000, 0, 0);
    xact(0, 1, 0, 2'd1, 0, 32'h0001_0000, 1);
    idle(); drain();

    // T4: collision at SCRATCH
    xact(0, 1, 1, 2'd2, 32'hA5A5_A5A5, 0, 0);
    xact(0, 1, 0, 2'd1, 0, 32'h0401_0000, 1);
    xact(0, 1, 0, 2'd2, 0, 32'hA5A5_A5A5, 1);
    idle(); drain();
    chk("t4_rdv_count", n_rdv[0], n_exp[0]);

    // T5: reset with reads in flight
    xact(0, 0, 1, 2'd0, 32'h77, 0, 0);
    idle();
    chk("t5_pre_not_empty", {31'b0, ne_a[0]}, 32'd1);
    xact(0, 1, 0, 2'd3, 0, 0, 0);
    xact(0, 1, 0, 2'd3, 0, 0, 0);
    #2 rst_a[0] = 1'b1;
    xact(0, 1, 0, 2'd3, 0, 0, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("t5_rst_not_empty", {31'b0, ne_a[0]}, 32'd0);
    @(negedge clk);
    rst_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    chk("t5_rdv_count", n_rdv[0], n_exp[0]);
    xact(0, 1, 0, 2'd1, 0, 32'h0001_0000, 1);
    xact(0, 1, 0, 2'd2, 0, 32'd0, 1);
    idle(); drain();

    wrap(0);

    // T6: latency 1 and 4
    for (int d = 1; d < 3; d++) begin
      xact(d, 0, 1, 2'd2, 32'hBEEF_0000 + d, 0, 0);
      xact(d, 1, 0, 2'd2, 0, 32'hBEEF_0000 + d, 1);
      xact(d, 1, 0, 2'd3, 0, ID, 1);
      xact(d, 1, 0, 2'd1, 0, 32'h0001_0000, 1);
      idle(); drain();
      wrap(d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
